// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift sequencer: controller state encoding
// and the direction constants used on the request interface.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter built from and/or/not cells.
// Right: {fill, d[W-1:1]}.  Left: {d[W-2:0], 1'b0}.
// dir_i follows the package encoding: 1 = left, 0 = right.
module shift_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] d_i,
    input  logic         dir_i,
    input  logic         fill_i,
    output logic [W-1:0] d_o
);

    logic dir_n;

    not u_dir_inv (dir_n, dir_i);

    // Each result bit is a 2:1 mux between its right and left neighbour.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic right_src;
        logic left_src;
        logic right_term;
        logic left_term;

        if (i == W - 1) begin : g_msb
            assign right_src = fill_i;
        end else begin : g_mid_r
            assign right_src = d_i[i+1];
        end

        if (i == 0) begin : g_lsb
            assign left_src = 1'b0;
        end else begin : g_mid_l
            assign left_src = d_i[i-1];
        end

        and u_and_r (right_term, dir_n, right_src);
        and u_and_l (left_term, dir_i, left_src);
        or  u_or    (d_o[i], right_term, left_term);
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts an operand over valid/ready, applies
// one single-position shift per clock, and returns the result over
// valid/ready. Amounts above W are clamped to W and flagged on amt_sat.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic          in_dir,
    input  logic          in_arith,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy,
    output logic          amt_sat
);

    localparam logic [AW-1:0] AMT_MAX = AW'(W);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);

    state_e        state_q, state_d;
    logic [W-1:0]  data_q,  data_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic          dir_q,   dir_d;
    logic          arith_q, arith_d;
    logic          sat_q,   sat_d;

    logic          fill;
    logic [W-1:0]  step_data;
    logic          req_sat;
    logic [AW-1:0] req_amt;

    // Arithmetic fill copies the current MSB; left shifts always fill zero.
    assign fill = (dir_q == DIR_RIGHT) & arith_q & data_q[W-1];

    assign req_sat = in_amt > AMT_MAX;
    assign req_amt = req_sat ? AMT_MAX : in_amt;

    shift_step #(.W(W)) u_step (
        .d_i    (data_q),
        .dir_i  (dir_q),
        .fill_i (fill),
        .d_o    (step_data)
    );

    assign out_data = data_q;
    assign amt_sat  = sat_q;

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        arith_d   = arith_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                busy   = 1'b1;
                data_d = step_data;
                cnt_d  = cnt_q - AMT_ONE;
                if (cnt_q <= AMT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request overrides the DONE -> IDLE step, so back-to-back
        // operations run without a bubble.
        if (in_valid && in_ready) begin
            data_d  = in_data;
            dir_d   = in_dir;
            arith_d = in_arith;
            cnt_d   = req_amt;
            sat_d   = req_sat;
            state_d = (req_amt == '0) ? DONE : SHIFT;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            arith_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a job-level reference model is
// compared against the DUT every cycle, and directed operations pin the
// model with hand-computed results, latencies and busy counts.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int AW = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [AW-1:0] in_amt    = '0;
    logic          in_dir    = 1'b0;
    logic          in_arith  = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          amt_sat;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .amt_sat   (amt_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the whole N-position shift in one arithmetic expression.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int k,
                                               input logic dir, input logic ar);
        logic signed [W-1:0] s;
        logic [W-1:0]        r;
        s = d;
        if (dir)     r = d << k;
        else if (ar) r = s >>> k;
        else         r = d >> k;
        return r;
    endfunction

    // Job model: one job in flight, m_rem cycles of work left before it is ready.
    bit           m_has = 1'b0;
    int           m_rem = 0;
    logic [W-1:0] m_res = '0;
    bit           m_sat = 1'b0;
    logic         m_ready;

    assign m_ready = !m_has || (m_rem == 0 && out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has <= 1'b0;
            m_rem <= 0;
            m_sat <= 1'b0;
        end else if (in_valid && m_ready) begin
            m_has <= 1'b1;
            m_rem <= (int'(in_amt) > W) ? W : int'(in_amt);
            m_res <= ref_shift(in_data, (int'(in_amt) > W) ? W : int'(in_amt), in_dir, in_arith);
            m_sat <= int'(in_amt) > W;
        end else if (m_has && m_rem == 0 && out_ready) begin
            m_has <= 1'b0;
        end else if (m_has && m_rem != 0) begin
            m_rem <= m_rem - 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("in_ready", in_ready, m_ready);
            check("out_valid", out_valid, m_has && m_rem == 0);
            check("busy", busy, m_has && m_rem != 0);
            if (m_has && m_rem == 0) begin
                check("out_data", out_data, m_res);
                check("amt_sat", amt_sat, m_sat);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a,
                        input logic dir, input logic ar);
        int n;
        bit rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_arith = ar;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end
        check("accept_in_time", rdy, 1);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after accept until out_valid; scrambles request fields meanwhile.
    task automatic wait_result(input string tag, input logic [W-1:0] exp_data,
                               input logic exp_sat, input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        bit seen;
        lat  = 0;
        bcnt = 0;
        seen = 1'b0;
        while (lat < 50) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            in_data  = W'($urandom);
            in_amt   = AW'($urandom);
            in_dir   = 1'($urandom);
            in_arith = 1'($urandom);
            lat++;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bcnt, exp_busy);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_sat"}, amt_sat, exp_sat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_amt_sat", amt_sat, 0);
        check("rst_out_data", out_data, 0);
        #10;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        send(4'b1011, 3'd2, 1'b0, 1'b0); wait_result("lsr2", 4'b0010, 1'b0, 2, 2);
        send(4'b1011, 3'd2, 1'b0, 1'b1); wait_result("asr2", 4'b1110, 1'b0, 2, 2);
        send(4'b1011, 3'd1, 1'b1, 1'b0); wait_result("lsl1", 4'b0110, 1'b0, 1, 1);
        send(4'b1011, 3'd0, 1'b0, 1'b0); wait_result("amt0", 4'b1011, 1'b0, 0, 0);
        send(4'b1011, 3'd7, 1'b0, 1'b0); wait_result("lsr7", 4'b0000, 1'b1, 4, 4);
        send(4'b1000, 3'd7, 1'b0, 1'b1); wait_result("asr7", 4'b1111, 1'b1, 4, 4);
        send(4'b1011, 3'd4, 1'b1, 1'b0); wait_result("lsl4", 4'b0000, 1'b0, 4, 4);

        // Backpressure, then a same-cycle take and new accept.
        send(4'b1101, 3'd2, 1'b0, 1'b1);
        out_ready = 1'b0;
        wait_result("hold", 4'b1111, 1'b0, 2, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 4'b1111);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b0001;
        in_amt    = 3'd1;
        in_dir    = 1'b1;
        in_arith  = 1'b0;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("b2b", 4'b0010, 1'b0, 1, 1);

        // Reset during the second SHIFT cycle.
        send(4'b1111, 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_amt_sat", amt_sat, 0);
        check("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(4'b1000, 3'd3, 1'b0, 1'b0); wait_result("post_rst", 4'b0001, 1'b0, 3, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
